// File: rtl/alu_seq_pkg.sv
// Shared types for alu_seq: opcode and FSM state enums plus opcode legality helpers.
// The SHIFT state only exists when ALU_SEQ_SHIFT_EN is defined.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_NOR  = 4'd5,
      OP_NOT  = 4'd6,
      OP_PASS = 4'd7,
      OP_SLL  = 4'd8,
      OP_SRL  = 4'd9,
      OP_SRA  = 4'd10
   } op_e;

   localparam int NUM_OPS = 11;

`ifdef ALU_SEQ_SHIFT_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DONE  = 2'd2
   } state_e;
`endif

   function automatic logic op_is_shift(input logic [3:0] o);
      return (o == OP_SLL) || (o == OP_SRL) || (o == OP_SRA);
   endfunction

   // Without the shifter the shift opcodes fall back to the illegal-op response.
   function automatic logic op_is_legal(input logic [3:0] o);
`ifdef ALU_SEQ_SHIFT_EN
      return int'(o) < NUM_OPS;
`else
      return (int'(o) < NUM_OPS) && !op_is_shift(o);
`endif
   endfunction

endpackage

// File: rtl/alu_addsub_core.sv
// Combinational adder/subtractor: carry is carry-out (no-borrow for subtract),
// overflow is two's-complement signed overflow.
module alu_addsub_core #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   logic [WIDTH-1:0] y_eff;

   // Subtraction is x + ~y + 1, so the carry-out directly means "no borrow".
   assign y_eff = sub ? ~y : y;
   assign {carry, sum} = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
   assign overflow = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake; single-cycle ops go straight to DONE.
// Define ALU_SEQ_SHIFT_EN to build the one-bit-per-cycle shifter (ops 8-10, SHIFT state).
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] value,
   output logic             carry,
   output logic             zeroflag,
   output logic             msb,
   output logic             overflow,
   output logic             err
);

   import alu_seq_pkg::*;

   localparam int SHW = $clog2(WIDTH);

   if (WIDTH < 8 || WIDTH > 64 || SHW < 3) begin : g_width_check
      $error("alu_seq: WIDTH must be in 8..64");
   end

   state_e           state;
   state_e           state_next;
   logic             take;
   logic [WIDTH-1:0] core_sum;
   logic             core_carry;
   logic             core_ovf;
   logic [WIDTH-1:0] res;
   logic             res_carry;
   logic             res_ovf;
   logic             res_err;

`ifdef ALU_SEQ_SHIFT_EN
   logic [WIDTH-1:0] shreg;
   logic [SHW-1:0]   count;
   logic             shcarry;
   op_e              shop;
`endif

   alu_addsub_core #(.WIDTH(WIDTH)) u_addsub (
      .x        (x),
      .y        (y),
      .sub      (op == OP_SUB),
      .sum      (core_sum),
      .carry    (core_carry),
      .overflow (core_ovf)
   );

   assign in_ready  = (state == ST_IDLE) && !rst;
   assign take      = in_valid && in_ready;
   assign out_valid = (state == ST_DONE);

   // Single-cycle result; illegal ops leave res at zero with err raised.
   always_comb begin
      res       = '0;
      res_carry = 1'b0;
      res_ovf   = 1'b0;
      res_err   = !op_is_legal(op);
      case (op)
         OP_ADD, OP_SUB: begin
            res       = core_sum;
            res_carry = core_carry;
            res_ovf   = core_ovf;
         end
         OP_AND:  res = x & y;
         OP_OR:   res = x | y;
         OP_XOR:  res = x ^ y;
         OP_NOR:  res = ~(x | y);
         OP_NOT:  res = ~x;
         OP_PASS: res = y;
         default: res = '0;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (take) begin
`ifdef ALU_SEQ_SHIFT_EN
               state_next = op_is_shift(op) ? ST_SHIFT : ST_DONE;
`else
               state_next = ST_DONE;
`endif
            end
         end
`ifdef ALU_SEQ_SHIFT_EN
         ST_SHIFT: begin
            if (count == '0) state_next = ST_DONE;
         end
`endif
         ST_DONE: begin
            if (out_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Result registers only change on a completing edge, so they hold through DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         value    <= '0;
         carry    <= 1'b0;
         zeroflag <= 1'b0;
         msb      <= 1'b0;
         overflow <= 1'b0;
         err      <= 1'b0;
`ifdef ALU_SEQ_SHIFT_EN
         shreg    <= '0;
         count    <= '0;
         shcarry  <= 1'b0;
         shop     <= OP_SLL;
`endif
      end else begin
`ifdef ALU_SEQ_SHIFT_EN
         if (take && op_is_shift(op)) begin
            shreg   <= x;
            count   <= y[SHW-1:0];
            shcarry <= 1'b0;
            shop    <= op_e'(op);
         end else if (take) begin
            value    <= res;
            carry    <= res_carry;
            overflow <= res_ovf;
            err      <= res_err;
            zeroflag <= (res == '0);
            msb      <= res[WIDTH-1];
         end else if (state == ST_SHIFT) begin
            if (count == '0) begin
               value    <= shreg;
               carry    <= shcarry;
               overflow <= 1'b0;
               err      <= 1'b0;
               zeroflag <= (shreg == '0);
               msb      <= shreg[WIDTH-1];
            end else begin
               count <= count - SHW'(1);
               case (shop)
                  OP_SLL:  {shcarry, shreg} <= {shreg, 1'b0};
                  OP_SRL:  {shreg, shcarry} <= {1'b0, shreg};
                  default: {shreg, shcarry} <= {shreg[WIDTH-1], shreg};
               endcase
            end
         end
`else
         if (take) begin
            value    <= res;
            carry    <= res_carry;
            overflow <= res_ovf;
            err      <= res_err;
            zeroflag <= (res == '0);
            msb      <= res[WIDTH-1];
         end
`endif
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): a spec-level model checked every cycle,
// plus directed vectors with literal expectations; expectations follow ALU_SEQ_SHIFT_EN.
module tb_alu_seq;

`ifdef ALU_SEQ_SHIFT_EN
   localparam bit SHIFT_EN = 1'b1;
`else
   localparam bit SHIFT_EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] value;
      logic        carry;
      logic        ovf;
      logic        err;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] x = '0;
   logic [31:0] y = '0;
   logic [3:0]  op = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] value;
   logic        carry, zeroflag, msb, overflow, err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .value     (value),
      .carry     (carry),
      .zeroflag  (zeroflag),
      .msb       (msb),
      .overflow  (overflow),
      .err       (err)
   );

   function automatic logic is_shift_op(input logic [3:0] o);
      return SHIFT_EN && (o == 4'd8 || o == 4'd9 || o == 4'd10);
   endfunction

   // Arithmetic meaning of each opcode, using wide signed math for overflow.
   function automatic res_t model_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      res_t   r;
      longint sa, sb, s;
      int     n;
      r  = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      n  = int'(b[4:0]);
      case (o)
         4'd0: begin
            {r.carry, r.value} = {1'b0, a} + {1'b0, b};
            s = sa + sb;
            r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd1: begin
            r.value = a - b;
            r.carry = (a >= b);
            s = sa - sb;
            r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd2: r.value = a & b;
         4'd3: r.value = a | b;
         4'd4: r.value = a ^ b;
         4'd5: r.value = ~(a | b);
         4'd6: r.value = ~a;
         4'd7: r.value = b;
         4'd8, 4'd9, 4'd10: begin
            if (is_shift_op(o)) begin
               if (o == 4'd8)      r.value = a << n;
               else if (o == 4'd9) r.value = a >> n;
               else                r.value = $signed(a) >>> n;
               if (n == 0)         r.carry = 1'b0;
               else if (o == 4'd8) r.carry = a[32-n];
               else                r.carry = a[n-1];
            end else begin
               r.err = 1'b1;
            end
         end
         default: r.err = 1'b1;
      endcase
      return r;
   endfunction

   function automatic int model_busy(input logic [3:0] o, input logic [31:0] b);
      return is_shift_op(o) ? int'(b[4:0]) + 1 : 0;
   endfunction

   // Model: 0 = waiting for operands, 1 = shifting, 2 = result held.
   int          m_phase = 0;
   int          m_rem   = 0;
   bit          m_clean = 1'b1;
   res_t        m_pend  = '0;
   logic [31:0] m_val = '0;
   logic        m_c = 1'b0, m_z = 1'b0, m_m = 1'b0, m_o = 1'b0, m_e = 1'b0;

   task automatic commit_model();
      m_phase = 2;
      m_val   = m_pend.value;
      m_c     = m_pend.carry;
      m_o     = m_pend.ovf;
      m_e     = m_pend.err;
      m_z     = (m_pend.value == 32'd0);
      m_m     = m_pend.value[31];
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_clean = 1'b1;
         m_val   = '0;
         {m_c, m_z, m_m, m_o, m_e} = '0;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
               m_pend  = model_op(op, x, y);
               m_clean = 1'b0;
               m_rem   = model_busy(op, y);
               if (m_rem == 0) commit_model();
               else            m_phase = 1;
            end
            1: begin
               m_rem = m_rem - 1;
               if (m_rem == 0) commit_model();
            end
            default: if (out_ready) m_phase = 0;
         endcase
      end
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      #1;
      check_output("cyc_in_ready", 64'(in_ready), 64'(m_phase == 0 && !rst));
      check_output("cyc_out_valid", 64'(out_valid), 64'(m_phase == 2));
      if (m_phase == 2 || m_clean) begin
         check_output("cyc_value", 64'(value), 64'(m_val));
         check_output("cyc_flags", 64'({carry, zeroflag, msb, overflow, err}),
                      64'({m_c, m_z, m_m, m_o, m_e}));
      end
   end

   task automatic apply_stimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output int busy);
      int t;
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check_output("ready_wait", 64'(in_ready), 64'd1);
      op = o;
      x = a;
      y = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      x = ~a;
      y = ~b;
      op = 4'd2;
      busy = 0;
      while (!out_valid && busy < 64) begin
         @(negedge clk);
         busy++;
      end
      check_output("result_wait", 64'(out_valid), 64'd1);
   endtask

   task automatic check_result(input string name, input logic [31:0] ev, input logic ec, input logic ez,
                               input logic em, input logic eo, input logic ee,
                               input int busy, input int ebusy);
      check_output({name, "_value"}, 64'(value), 64'(ev));
      check_output({name, "_carry"}, 64'(carry), 64'(ec));
      check_output({name, "_zero"}, 64'(zeroflag), 64'(ez));
      check_output({name, "_msb"}, 64'(msb), 64'(em));
      check_output({name, "_ovf"}, 64'(overflow), 64'(eo));
      check_output({name, "_err"}, 64'(err), 64'(ee));
      check_output({name, "_busy"}, 64'(busy), 64'(ebusy));
   endtask

   // Offer a new operation in the consume cycle too; it must not be taken.
   task automatic consume();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check_output("consume_in_ready", 64'(in_ready), 64'd1);
      check_output("consume_out_valid", 64'(out_valid), 64'd0);
   endtask

   initial begin
      int   busy;
      res_t r;
      logic [31:0] xa, yb;

      repeat (2) @(negedge clk);
      check_output("rst_in_ready", 64'(in_ready), 64'd0);
      check_output("rst_out_valid", 64'(out_valid), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check_output("post_rst_in_ready", 64'(in_ready), 64'd1);
      check_output("post_rst_value", 64'(value), 64'd0);
      check_output("post_rst_flags", 64'({carry, zeroflag, msb, overflow, err}), 64'd0);

      apply_stimulus(4'd0, 32'hFFFF_FFFF, 32'h1, busy);
      check_result("add_wrap", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, busy, 0);
      consume();

      apply_stimulus(4'd1, 32'h8000_0000, 32'h1, busy);
      check_result("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, busy, 0);
      consume();

      apply_stimulus(4'd1, 32'h1, 32'h2, busy);
      check_result("sub_borrow", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, busy, 0);
      consume();

      apply_stimulus(4'd0, 32'h7FFF_FFFF, 32'h1, busy);
      check_result("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, busy, 0);
      consume();

      apply_stimulus(4'd5, 32'h0, 32'h0, busy);
      check_result("nor_zero", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, busy, 0);
      consume();

      apply_stimulus(4'd13, 32'h1234_5678, 32'h9, busy);
      check_result("illegal13", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, busy, 0);
      consume();

      apply_stimulus(4'd8, 32'h1, 32'h3, busy);
      check_result("sll_3", SHIFT_EN ? 32'h8 : 32'h0, 1'b0, !SHIFT_EN, 1'b0, 1'b0, !SHIFT_EN,
                   busy, SHIFT_EN ? 4 : 0);
      consume();

      apply_stimulus(4'd8, 32'h8000_0001, 32'h1, busy);
      check_result("sll_1", SHIFT_EN ? 32'h2 : 32'h0, SHIFT_EN, !SHIFT_EN, 1'b0, 1'b0, !SHIFT_EN,
                   busy, SHIFT_EN ? 2 : 0);
      consume();

      apply_stimulus(4'd9, 32'h3, 32'h0, busy);
      check_result("srl_0", SHIFT_EN ? 32'h3 : 32'h0, 1'b0, !SHIFT_EN, 1'b0, 1'b0, !SHIFT_EN,
                   busy, SHIFT_EN ? 1 : 0);
      consume();

      apply_stimulus(4'd10, 32'h8000_0001, 32'h4, busy);
      check_result("sra_4", SHIFT_EN ? 32'hF800_0000 : 32'h0, 1'b0, !SHIFT_EN, SHIFT_EN, 1'b0,
                   !SHIFT_EN, busy, SHIFT_EN ? 5 : 0);
      op = 4'd0;
      x = 32'h1;
      y = 32'h1;
      in_valid = 1'b1;
      repeat (10) @(negedge clk);
      in_valid = 1'b0;
      check_result("sra_hold", SHIFT_EN ? 32'hF800_0000 : 32'h0, 1'b0, !SHIFT_EN, SHIFT_EN, 1'b0,
                   !SHIFT_EN, busy, SHIFT_EN ? 5 : 0);
      consume();

      for (int i = 0; i < 16; i++) begin
         xa = 32'hA5A5_F00F ^ (32'(i) << 7);
         yb = 32'(i * 3) | ((i % 2 == 0) ? 32'h8000_0000 : 32'h0);
         apply_stimulus(4'(i), xa, yb, busy);
         r = model_op(4'(i), xa, yb);
         check_output("tbl_value", 64'(value), 64'(r.value));
         check_output("tbl_busy", 64'(busy), 64'(model_busy(4'(i), yb)));
         consume();
      end

      op = 4'd8;
      x = 32'hFFFF_FFFF;
      y = 32'd31;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check_output("rst_mid_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_output("abort_out_valid", 64'(out_valid), 64'd0);
      check_output("abort_value", 64'(value), 64'd0);
      check_output("abort_flags", 64'({carry, zeroflag, msb, overflow, err}), 64'd0);
      check_output("abort_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);

      apply_stimulus(4'd0, 32'h2, 32'h3, busy);
      check_result("add_after_rst", 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, busy, 0);
      consume();

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width (legal 8..64).
REQ-002 SHALL have localparam SHW = $clog2(WIDTH), meaning shift-amount width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset is synchronous and active-high.
REQ-005 SHALL have ports in_valid (input, 1, operands valid) and in_ready (output, 1, block can accept).
REQ-006 SHALL have ports x and y, input, WIDTH each, operands.
REQ-007 SHALL have port op, input, 4, opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 NOT x, 7 PASS y, 8 SLL, 9 SRL, 10 SRA; 11-15 are illegal.
REQ-008 SHALL have ports out_valid (output, 1, result held) and out_ready (input, 1, consumer accepts).
REQ-009 SHALL have port value, output, WIDTH, registered result.
REQ-010 SHALL have flag outputs carry, zeroflag, msb, overflow and err, each output, 1, registered.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 SHALL drive in_ready = 1 only in IDLE with rst low; a transfer occurs when in_valid && in_ready.
REQ-013 SHALL, for ops 0-7 and illegal ops, go IDLE -> DONE on transfer, with results registered in the same edge (out_valid the next cycle).
REQ-014 SHALL, for ops 8-10, go IDLE -> SHIFT on transfer, loading x and count = y[SHW-1:0], and shift one bit per cycle while decrementing count.
REQ-015 SHALL go SHIFT -> DONE on the edge at which count is 0, so out_valid follows the transfer by count+1 cycles (shift by 0 takes 1 cycle).
REQ-016 SHALL hold value and all flags stable in DONE, and go DONE -> IDLE when out_ready is 1, dropping out_valid on that edge.
REQ-017 SHALL ignore in_valid, x, y and op outside IDLE; the block never accepts a new operation in the cycle a result is consumed.
REQ-018 SHALL compute ADD as x+y mod 2^WIDTH, with carry = carry-out and overflow = signed overflow.
REQ-019 SHALL compute SUB as x-y mod 2^WIDTH, with carry = 1 when there is no borrow (x >= y unsigned) and overflow = signed overflow.
REQ-020 SHALL clear carry and overflow for logic ops and PASS.
REQ-021 SHALL, for shifts, set carry = last bit shifted out (0 if count is 0) and clear overflow; SRA replicates x[WIDTH-1].
REQ-022 SHALL set zeroflag = (value == 0) and msb = value[WIDTH-1], both from the final registered result.
REQ-023 SHALL, for an illegal op, set value = 0, err = 1, zeroflag = 1, and all other flags 0; err is 0 for every legal op.

Reset
REQ-024 SHALL, when rst is high at an edge, force state IDLE and clear value, carry, zeroflag, msb, overflow, err, out_valid and count to 0, aborting any shift or pending result.
REQ-025 SHALL hold in_ready at 0 while rst is high and at 1 in the first cycle after rst is released.

Configuration
REQ-026 SHALL, when macro ALU_SEQ_SHIFT_EN is defined, implement ops 8-10 and the SHIFT state as specified.
REQ-027 SHALL, when ALU_SEQ_SHIFT_EN is undefined, omit the SHIFT state and the count logic, and treat ops 8-10 as illegal per REQ-023 (1-cycle latency).

Structure
REQ-028 SHALL place the opcode enum, the FSM state enum and the opcode-count constant in package alu_seq_pkg.
REQ-029 SHALL instantiate one combinational sub-module, alu_addsub_core, that takes x, y and sub and returns sum, carry and overflow; alu_seq registers its outputs.

Verification (WIDTH=32)
REQ-030 SHALL check: ADD x=FFFFFFFF, y=1 -> value 0, carry 1, zeroflag 1, overflow 0, out_valid 1 cycle after transfer.
REQ-031 SHALL check: SUB x=80000000, y=1 -> value 7FFFFFFF, overflow 1, carry 1, msb 0; SUB x=1, y=2 -> FFFFFFFF, carry 0.
REQ-032 SHALL check: SRA x=80000001, y=4 -> value F8000000, carry 0, out_valid 5 cycles after transfer, in_ready 0 throughout.
REQ-033 SHALL check: result held with out_ready=0 for 10 cycles -> value and flags stable, new in_valid ignored; out_ready=1 -> IDLE, in_ready 1 the next cycle.
REQ-034 SHALL check: rst pulsed during SLL by 31 -> next cycle out_valid 0, value 0 and all flags 0, in_ready 1 after release.
REQ-035 SHALL check: op=13 -> value 0, err 1, zeroflag 1; with ALU_SEQ_SHIFT_EN undefined, op=8 gives the same response.
